// File: rtl/sw_debounce.sv
// Push-button conditioner: 2-flop synchronizer plus per-switch debounce FSM producing level, press and release.
// Define SW_AUTOREPEAT_EN to compile in hold-to-repeat press pulses.
module sw_debounce #(
    parameter int N_SW            = 4,
    parameter int DEBOUNCE_CYC    = 500000,
    parameter int REPEAT_DLY_CYC  = 25000000,
    parameter int REPEAT_RATE_CYC = 5000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_level,
    output logic [N_SW-1:0] sw_press,
    output logic [N_SW-1:0] sw_release
);

    localparam int MAX_AB  = (DEBOUNCE_CYC > REPEAT_DLY_CYC) ? DEBOUNCE_CYC : REPEAT_DLY_CYC;
    localparam int MAX_CYC = (MAX_AB > REPEAT_RATE_CYC) ? MAX_AB : REPEAT_RATE_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    // The counter is cleared on entry to a check state, so that entry is the first stable sample.
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 2);
`ifdef SW_AUTOREPEAT_EN
    localparam logic [CW-1:0] RPT_DLY_LAST  = CW'(REPEAT_DLY_CYC - 1);
    localparam logic [CW-1:0] RPT_RATE_LAST = CW'(REPEAT_RATE_CYC - 1);
`endif

    typedef enum logic [1:0] {
        REL,
        PRS_CHK,
        HELD,
        REL_CHK
    } sw_state_t;

    logic [N_SW-1:0] s1;
    logic [N_SW-1:0] s2;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_raw;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        sw_state_t     state;
        sw_state_t     state_nxt;
        logic [CW-1:0] db_cnt;
        logic [CW-1:0] db_cnt_nxt;
        logic          level_q;
        logic          level_nxt;
        logic          press_q;
        logic          press_nxt;
        logic          release_q;
        logic          release_nxt;
`ifdef SW_AUTOREPEAT_EN
        logic [CW-1:0] rpt_cnt;
        logic [CW-1:0] rpt_cnt_nxt;
        logic          rpt_fast;
        logic          rpt_fast_nxt;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                state     <= REL;
                db_cnt    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef SW_AUTOREPEAT_EN
                rpt_cnt   <= '0;
                rpt_fast  <= 1'b0;
`endif
            end else begin
                state     <= state_nxt;
                db_cnt    <= db_cnt_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
`ifdef SW_AUTOREPEAT_EN
                rpt_cnt   <= rpt_cnt_nxt;
                rpt_fast  <= rpt_fast_nxt;
`endif
            end
        end

        always_comb begin
            state_nxt    = state;
            db_cnt_nxt   = db_cnt;
            level_nxt    = level_q;
            press_nxt    = 1'b0;
            release_nxt  = 1'b0;
`ifdef SW_AUTOREPEAT_EN
            rpt_cnt_nxt  = rpt_cnt;
            rpt_fast_nxt = rpt_fast;
`endif
            case (state)
                REL: begin
                    if (s2[i]) begin
                        state_nxt  = PRS_CHK;
                        db_cnt_nxt = '0;
                    end
                end
                PRS_CHK: begin
                    if (!s2[i]) begin
                        state_nxt = REL;
                    end else if (db_cnt >= DB_LAST) begin
                        state_nxt    = HELD;
                        level_nxt    = 1'b1;
                        press_nxt    = 1'b1;
`ifdef SW_AUTOREPEAT_EN
                        rpt_cnt_nxt  = '0;
                        rpt_fast_nxt = 1'b0;
`endif
                    end else begin
                        db_cnt_nxt = sat_inc(db_cnt);
                    end
                end
                HELD: begin
                    if (!s2[i]) begin
                        state_nxt  = REL_CHK;
                        db_cnt_nxt = '0;
                    end
`ifdef SW_AUTOREPEAT_EN
                    // First repeat waits the long delay, later ones use the shorter rate.
                    else if (rpt_cnt >= (rpt_fast ? RPT_RATE_LAST : RPT_DLY_LAST)) begin
                        press_nxt    = 1'b1;
                        rpt_cnt_nxt  = '0;
                        rpt_fast_nxt = 1'b1;
                    end else begin
                        rpt_cnt_nxt = sat_inc(rpt_cnt);
                    end
`endif
                end
                REL_CHK: begin
                    if (s2[i]) begin
                        state_nxt = HELD;
                    end else if (db_cnt >= DB_LAST) begin
                        state_nxt   = REL;
                        level_nxt   = 1'b0;
                        release_nxt = 1'b1;
                    end else begin
                        db_cnt_nxt = sat_inc(db_cnt);
                    end
                end
                default: begin
                    state_nxt = REL;
                end
            endcase
        end

        assign sw_level[i]   = level_q;
        assign sw_press[i]   = press_q;
        assign sw_release[i] = release_q;
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: table-driven press/release vectors plus hand-written
// bounce, auto-repeat and reset sequences, all checked through a cycle-stamped scoreboard.
module tb_sw_debounce;

    localparam int N_SW = 4;
    localparam int DB   = 8;
    localparam int DLY  = 40;
    localparam int RATE = 10;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
    } exp_t;

    typedef struct {
        string      name;
        logic [3:0] raw;
        logic [3:0] lvl_before;
        logic [3:0] lvl_after;
        logic [3:0] prs_after;
        logic [3:0] rel_after;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw_raw;
    logic [3:0] sw_level;
    logic [3:0] sw_press;
    logic [3:0] sw_release;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   press_cnt[4];
    int   rel_cnt[4];
    exp_t exp_q[$];
    vec_t vecs[7];

    sw_debounce #(
        .N_SW           (N_SW),
        .DEBOUNCE_CYC   (DB),
        .REPEAT_DLY_CYC (DLY),
        .REPEAT_RATE_CYC(RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .sw_level  (sw_level),
        .sw_press  (sw_press),
        .sw_release(sw_release)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input int at, input string name, input logic [3:0] lvl,
                            input logic [3:0] prs, input logic [3:0] rel);
        exp_t e;
        e.cyc  = at;
        e.name = name;
        e.lvl  = lvl;
        e.prs  = prs;
        e.rel  = rel;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input exp_t e);
        n_checks++;
        if (e.cyc != cyc) begin
            $display("[TB] FAIL %s: expectation for cyc %0d reached at cyc %0d", e.name, e.cyc, cyc);
        end else if (sw_level !== e.lvl || sw_press !== e.prs || sw_release !== e.rel) begin
            $display("[TB] FAIL %s @cyc %0d: got lvl=%b prs=%b rel=%b, want lvl=%b prs=%b rel=%b",
                     e.name, cyc, sw_level, sw_press, sw_release, e.lvl, e.prs, e.rel);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_count(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock at a time, sampling 1 time unit after the edge and draining due expectations.
    task automatic tick(input int n);
        exp_t e;
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (sw_press[i] === 1'b1) press_cnt[i]++;
                if (sw_release[i] === 1'b1) rel_cnt[i]++;
            end
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    endtask

    // Raw changes before edge 0; the debounced result must appear after edge DB+1 and last one cycle.
    task automatic apply_stimulus(input vec_t v);
        int base;
        sw_raw = v.raw;
        base   = cyc + 1;
        push_exp(base + DB,     {v.name, "_pre"},  v.lvl_before, 4'b0000,     4'b0000);
        push_exp(base + DB + 1, v.name,            v.lvl_after,  v.prs_after, v.rel_after);
        push_exp(base + DB + 2, {v.name, "_post"}, v.lvl_after,  4'b0000,     4'b0000);
        tick(20);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int acc;
        int e0;
        int e1;
        int p0;
        int r0;
        logic [3:0] prs;

        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
        end

        vecs[0] = '{"press0",      4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
        vecs[1] = '{"release0",    4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
        vecs[2] = '{"press_all",   4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000};
        vecs[3] = '{"release_all", 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1111};
        vecs[4] = '{"press_23",    4'b1100, 4'b0000, 4'b1100, 4'b1100, 4'b0000};
        vecs[5] = '{"swap",        4'b0011, 4'b1100, 4'b0011, 4'b0011, 4'b1100};
        vecs[6] = '{"release_01",  4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0011};

        rst    = 1'b1;
        sw_raw = 4'b0000;
        tick(1);
        push_exp(cyc + 1, "reset", 4'b0000, 4'b0000, 4'b0000);
        push_exp(cyc + 2, "reset", 4'b0000, 4'b0000, 4'b0000);
        tick(3);
        rst = 1'b0;
        push_exp(cyc + 1, "post_reset", 4'b0000, 4'b0000, 4'b0000);
        tick(2);

        for (int k = 0; k < 7; k++) begin
            apply_stimulus(vecs[k]);
        end

        // Bounce on switch 1 with 3-cycle halves: nothing may ever leave the block.
        p0 = press_cnt[1];
        r0 = rel_cnt[1];
        for (int k = 1; k <= 50; k++) begin
            push_exp(cyc + k, "bounce", 4'b0000, 4'b0000, 4'b0000);
        end
        for (int k = 0; k < 5; k++) begin
            sw_raw[1] = 1'b1;
            tick(3);
            sw_raw[1] = 1'b0;
            tick(3);
        end
        tick(20);
        check_count("bounce_press_cnt", press_cnt[1] - p0, 0);
        check_count("bounce_rel_cnt", rel_cnt[1] - r0, 0);

        // A 5-cycle glitch, a short gap, then a steady press accepted exactly once.
        p0 = press_cnt[1];
        r0 = rel_cnt[1];
        sw_raw[1] = 1'b1;
        tick(5);
        sw_raw[1] = 1'b0;
        tick(3);
        sw_raw[1] = 1'b1;
        base = cyc + 1;
        push_exp(base + DB,     "settle_pre",  4'b0000, 4'b0000, 4'b0000);
        push_exp(base + DB + 1, "settle",      4'b0010, 4'b0010, 4'b0000);
        push_exp(base + DB + 2, "settle_post", 4'b0010, 4'b0000, 4'b0000);
        tick(30);
        check_count("settle_press_cnt", press_cnt[1] - p0, 1);
        sw_raw[1] = 1'b0;
        tick(20);
        check_count("settle_rel_cnt", rel_cnt[1] - r0, 1);

        // Long hold on switch 2; every cycle from just before acceptance to after release is checked.
        p0 = press_cnt[2];
        sw_raw[2] = 1'b1;
        base = cyc + 1;
        acc  = base + DB + 1;
        for (int r = -1; r <= 106; r++) begin
`ifdef SW_AUTOREPEAT_EN
            prs = (r == 0 || (r >= DLY && r <= 90 && (r - DLY) % RATE == 0)) ? 4'b0100 : 4'b0000;
`else
            prs = (r == 0) ? 4'b0100 : 4'b0000;
`endif
            push_exp(acc + r, "hold_repeat",
                     (r >= 0 && r < 105) ? 4'b0100 : 4'b0000,
                     prs,
                     (r == 105) ? 4'b0100 : 4'b0000);
        end
        tick((acc + 95) - cyc);
        sw_raw[2] = 1'b0;
        tick(30);
`ifdef SW_AUTOREPEAT_EN
        check_count("repeat_press_cnt", press_cnt[2] - p0, 7);
`else
        check_count("repeat_press_cnt", press_cnt[2] - p0, 1);
`endif

        // Reset during PRS_CHK and again during HELD with the switch still pressed.
        p0 = press_cnt[0];
        r0 = rel_cnt[0];
        sw_raw[0] = 1'b1;
        base = cyc + 1;
        tick((base + 4) - cyc);
        rst = 1'b1;
        push_exp(base + 5, "rst_in_prs_chk", 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        rst = 1'b0;
        e0 = cyc + 1;
        push_exp(e0 + DB,     "reaccept1_pre",  4'b0000, 4'b0000, 4'b0000);
        push_exp(e0 + DB + 1, "reaccept1",      4'b0001, 4'b0001, 4'b0000);
        push_exp(e0 + DB + 2, "reaccept1_post", 4'b0001, 4'b0000, 4'b0000);
        tick((e0 + 12) - cyc);
        rst = 1'b1;
        push_exp(e0 + 13, "rst_in_held",    4'b0000, 4'b0000, 4'b0000);
        push_exp(e0 + 14, "after_rst_held", 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        rst = 1'b0;
        e1 = cyc + 1;
        push_exp(e1 + DB,     "reaccept2_pre",  4'b0000, 4'b0000, 4'b0000);
        push_exp(e1 + DB + 1, "reaccept2",      4'b0001, 4'b0001, 4'b0000);
        push_exp(e1 + DB + 2, "reaccept2_post", 4'b0001, 4'b0000, 4'b0000);
        tick(15);
        check_count("rst_press_cnt", press_cnt[0] - p0, 2);
        check_count("rst_no_release", rel_cnt[0] - r0, 0);
        sw_raw[0] = 1'b0;
        tick(20);
        check_count("rst_final_release", rel_cnt[0] - r0, 1);

        tick(5);
        check_count("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
